mem_stage_stack_ctrl: RTL

//   Parametrised memory stage for the pipelined processor. Holds the data memory, an internal

---
 rtl/mem_stage_stack_ctrl.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/mem_stage_stack_ctrl.sv
// rtl/mem_stage_stack_ctrl.sv - memory stage with data memory, stack pointer and multi-beat PC push/pop
module mem_stage_stack_ctrl #(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 12,
  parameter int PC_W     = 32,
  parameter int SP_RESET = 2**ADDR_W - 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic              mem_to_reg,
  input  logic              stack_op,
  input  logic              push_pop,
  input  logic              push_pc,
  input  logic              pop_pc,
  input  logic              in_op,
  input  logic              out_op,
  input  logic [PC_W-1:0]   pc_in,
  input  logic [DATA_W-1:0] addr,
  input  logic [DATA_W-1:0] write_data,
  input  logic [DATA_W-1:0] alu_data,
  output logic [DATA_W-1:0] data_to_write,
  output logic [PC_W-1:0]   pc_out,
  output logic              pc_out_valid,
  output logic              stall,
  output logic              stack_fault
);

  localparam int PC_BEATS = PC_W / DATA_W;
  localparam int BEAT_W   = (PC_BEATS > 1) ? $clog2(PC_BEATS) : 1;
  localparam bit MULTI    = (PC_BEATS > 1);
  localparam logic [ADDR_W-1:0] SP_INIT   = ADDR_W'(SP_RESET);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(PC_BEATS - 1);

  typedef enum logic [1:0] {IDLE, PUSH_PC, POP_PC} state_t;

  state_t                 state, state_n;
  logic [BEAT_W-1:0]      beat, beat_n;
  logic [ADDR_W-1:0]      sp, sp_n;
  logic [PC_W-1:0]        pc_buf, pc_buf_n;
  logic [DATA_W-1:0]      mem [2**ADDR_W];

  logic                   busy, start_push, start_pop, do_push, do_pop;
  logic                   ovf, udf, last, pc_done, wr_en;
  logic [ADDR_W-1:0]      eff_addr;
  logic [DATA_W-1:0]      rd_word, wr_word;
  logic [PC_W+DATA_W-1:0] pop_shift;
  logic                   unused_inputs;

  // Memory is read combinationally, so mem_read only matters upstream.
  generate
    if (DATA_W > ADDR_W) begin : g_addr_hi
      assign unused_inputs = ^{mem_read, addr[DATA_W-1:ADDR_W]};
    end else begin : g_addr_full
      assign unused_inputs = mem_read;
    end
  endgenerate

  always_comb begin
    busy       = (state != IDLE);
    start_push = !busy && stack_op && push_pop && push_pc;
    start_pop  = !busy && stack_op && !push_pop && pop_pc;
    do_push    = busy ? (state == PUSH_PC) : (stack_op && push_pop);
    do_pop     = busy ? (state == POP_PC) : (stack_op && !push_pop);
    ovf        = do_push && (sp == '0);
    udf        = do_pop && (sp == SP_INIT);
    last       = busy ? (beat == LAST_BEAT) : !MULTI;

    if (do_push)     eff_addr = sp;
    else if (do_pop) eff_addr = sp + ADDR_W'(1);
    else             eff_addr = addr[ADDR_W-1:0];

    rd_word = udf ? '0 : mem[eff_addr];

    // PC words leave MSW first on push; pops shift in from the top so the LSW lands lowest.
    wr_word = write_data;
    if (start_push)  wr_word = pc_in[PC_W-1 -: DATA_W];
    else if (busy)   wr_word = pc_buf[PC_W-1 -: DATA_W];
    wr_en     = !reset && (do_push ? !ovf : (!do_pop && mem_write));
    pop_shift = {rd_word, pc_buf};

    sp_n = sp;
    if (do_push && !ovf)     sp_n = sp - ADDR_W'(1);
    else if (do_pop && !udf) sp_n = sp + ADDR_W'(1);

    state_n  = state;
    beat_n   = beat;
    pc_buf_n = pc_buf;
    pc_done  = 1'b0;
    case (state)
      IDLE: begin
        if (start_push && !ovf && MULTI) begin
          state_n  = PUSH_PC;
          beat_n   = BEAT_W'(1);
          pc_buf_n = pc_in << DATA_W;
        end else if (start_pop && !udf) begin
          pc_buf_n = pop_shift[PC_W+DATA_W-1:DATA_W];
          if (MULTI) begin
            state_n = POP_PC;
            beat_n  = BEAT_W'(1);
          end else begin
            pc_done = 1'b1;
          end
        end
      end
      PUSH_PC: begin
        pc_buf_n = pc_buf << DATA_W;
        if (ovf || last) begin
          state_n = IDLE;
          beat_n  = '0;
        end else begin
          beat_n = beat + BEAT_W'(1);
        end
      end
      POP_PC: begin
        pc_buf_n = pop_shift[PC_W+DATA_W-1:DATA_W];
        if (udf) begin
          state_n = IDLE;
          beat_n  = '0;
        end else if (last) begin
          state_n = IDLE;
          beat_n  = '0;
          pc_done = 1'b1;
        end else begin
          beat_n = beat + BEAT_W'(1);
        end
      end
      default: begin
        state_n = IDLE;
        beat_n  = '0;
      end
    endcase

    stall = ((start_push || start_pop) && MULTI) || (busy && !last);

    if (mem_to_reg || pop_pc) data_to_write = rd_word;
    else if (in_op || out_op) data_to_write = write_data;
    else                      data_to_write = alu_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      beat         <= '0;
      sp           <= SP_INIT;
      pc_buf       <= '0;
      stack_fault  <= 1'b0;
      pc_out       <= '0;
      pc_out_valid <= 1'b0;
    end else begin
      state        <= state_n;
      beat         <= beat_n;
      sp           <= sp_n;
      pc_buf       <= pc_buf_n;
      stack_fault  <= stack_fault || ovf || udf;
      pc_out_valid <= pc_done;
      if (pc_done) pc_out <= pc_buf_n;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[eff_addr] <= wr_word;
  end

endmodule
